// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control slice: register address width,
// memory-wait FSM encodings and the source/destination match helper.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W = 4;

  // Memory-wait FSM encodings
  localparam logic [0:0] ST_MEM_IDLE = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  // A source operand conflicts with an in-flight write when both are live
  // and the 4-bit register numbers are equal (no register is special).
  function automatic logic src_match(
    input logic                  src_used,
    input logic                  dst_wb,
    input logic [REG_ADDR_W-1:0] src,
    input logic [REG_ADDR_W-1:0] dst
  );
    return src_used & dst_wb & (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of the hazard/memory inputs and the stall/flush controls exchanged
// between the pipeline and its control block.
interface pipeline_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
);

  logic [REG_ADDR_W-1:0] id_rn;
  logic [REG_ADDR_W-1:0] id_rm;
  logic                  id_uses_rn;
  logic                  id_two_src;
  logic [REG_ADDR_W-1:0] exe_dest;
  logic                  exe_wb_en;
  logic [REG_ADDR_W-1:0] mem_dest;
  logic                  mem_wb_en;
  logic                  mem_req;
  logic                  branch_taken;

  logic                  if_freeze;
  logic                  ifr_en;
  logic                  ifr_clr;
  logic                  idr_en;
  logic                  idr_clr;
  logic                  exr_en;
  logic                  memr_en;
  logic                  hazard;
  logic                  mem_ready;
  logic [CNT_W-1:0]      hazard_cnt;
  logic [CNT_W-1:0]      mem_stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  // Pipeline side: supplies stage information, consumes controls
  modport master (
    output id_rn, id_rm, id_uses_rn, id_two_src, exe_dest, exe_wb_en,
           mem_dest, mem_wb_en, mem_req, branch_taken,
    input  if_freeze, ifr_en, ifr_clr, idr_en, idr_clr, exr_en, memr_en,
           hazard, mem_ready, hazard_cnt, mem_stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  id_rn, id_rm, id_uses_rn, id_two_src, exe_dest, exe_wb_en,
           mem_dest, mem_wb_en, mem_req, branch_taken,
    output if_freeze, ifr_en, ifr_clr, idr_en, idr_clr, exr_en, memr_en,
           hazard, mem_ready, hazard_cnt, mem_stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// RAW hazard detector: purely combinational comparison of the ID source
// registers against the EXE and MEM destinations (no forwarding).
module pipeline_ctrl_hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rn,
  input  logic [REG_ADDR_W-1:0] id_rm,
  input  logic                  id_uses_rn,
  input  logic                  id_two_src,
  input  logic [REG_ADDR_W-1:0] exe_dest,
  input  logic                  exe_wb_en,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic                  mem_wb_en,
  output logic                  raw
);

  // Any live source matching any pending writeback is a hazard
  always_comb begin
    raw = src_match(id_uses_rn, exe_wb_en, id_rn, exe_dest)
        | src_match(id_uses_rn, mem_wb_en, id_rn, mem_dest)
        | src_match(id_two_src, exe_wb_en, id_rm, exe_dest)
        | src_match(id_two_src, mem_wb_en, id_rm, mem_dest);
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline. Merges memory-wait stalls,
// EXE branch flushes and RAW hazards into stage enables/clears and keeps
// three wrapping event counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_WAIT = 3,
  parameter int CNT_W    = 16
) (
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  // A zero-wait build still needs a 1-bit counter to stay legal
  localparam int              CW       = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'((MEM_WAIT > 0) ? MEM_WAIT - 1 : 0);
  localparam logic            HAS_WAIT = (MEM_WAIT > 0);

  logic [0:0]    state;
  logic [0:0]    state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          mstall;
  logic          ready_c;
  logic          raw;
  logic          flush;

  logic          if_freeze;
  logic          ifr_en;
  logic          ifr_clr;
  logic          idr_en;
  logic          idr_clr;
  logic          exr_en;
  logic          memr_en;
  logic          hazard;

  logic [CNT_W-1:0] hazard_cnt;
  logic [CNT_W-1:0] mem_stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pipeline_ctrl_hazard_detect u_hazard (
    .id_rn      (bus.id_rn),
    .id_rm      (bus.id_rm),
    .id_uses_rn (bus.id_uses_rn),
    .id_two_src (bus.id_two_src),
    .exe_dest   (bus.exe_dest),
    .exe_wb_en  (bus.exe_wb_en),
    .mem_dest   (bus.mem_dest),
    .mem_wb_en  (bus.mem_wb_en),
    .raw        (raw)
  );

  // Memory-wait FSM next state, stall and completion decode
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mstall   = 1'b0;
    ready_c  = 1'b0;
    case (state)
      ST_MEM_IDLE: begin
        if (bus.mem_req) begin
          if (HAS_WAIT) begin
            mstall   = 1'b1;
            cnt_nx   = CNT_LOAD;
            state_nx = ST_MEM_WAIT;
          end else begin
            ready_c  = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (cnt != '0) begin
          mstall = 1'b1;
          cnt_nx = cnt - CW'(1);
        end else begin
          ready_c  = 1'b1;
          state_nx = ST_MEM_IDLE;
        end
      end
      default: state_nx = ST_MEM_IDLE;
    endcase
  end

  // Priority mux: memory stall over branch flush over RAW hazard
  always_comb begin
    if_freeze = 1'b0;
    ifr_en    = 1'b1;
    ifr_clr   = 1'b0;
    idr_en    = 1'b1;
    idr_clr   = 1'b0;
    exr_en    = 1'b1;
    memr_en   = 1'b1;
    hazard    = 1'b0;
    flush     = 1'b0;
    if (!rst) begin
      if (mstall) begin
        if_freeze = 1'b1;
        ifr_en    = 1'b0;
        idr_en    = 1'b0;
        exr_en    = 1'b0;
        memr_en   = 1'b0;
      end else if (bus.branch_taken) begin
        ifr_clr   = 1'b1;
        idr_clr   = 1'b1;
        flush     = 1'b1;
      end else if (raw) begin
        if_freeze = 1'b1;
        ifr_en    = 1'b0;
        idr_clr   = 1'b1;
        hazard    = 1'b1;
      end
    end
  end

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_MEM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Event counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      hazard_cnt    <= '0;
      mem_stall_cnt <= '0;
      flush_cnt     <= '0;
    end else begin
      if (hazard) hazard_cnt    <= hazard_cnt + CNT_W'(1);
      if (mstall) mem_stall_cnt <= mem_stall_cnt + CNT_W'(1);
      if (flush)  flush_cnt     <= flush_cnt + CNT_W'(1);
    end
  end

  assign bus.if_freeze     = if_freeze;
  assign bus.ifr_en        = ifr_en;
  assign bus.ifr_clr       = ifr_clr;
  assign bus.idr_en        = idr_en;
  assign bus.idr_clr       = idr_clr;
  assign bus.exr_en        = exr_en;
  assign bus.memr_en       = memr_en;
  assign bus.hazard        = hazard;
  assign bus.mem_ready     = ready_c & ~rst;
  assign bus.hazard_cnt    = hazard_cnt;
  assign bus.mem_stall_cnt = mem_stall_cnt;
  assign bus.flush_cnt     = flush_cnt;

endmodule
